// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : uart_rx                                                  |
// | Brief   : UART receiver, 8N1 by default, sampling at mid-bit.       |
// |           Define UART_RX_PARITY_EN for 8E1 with an even-parity check.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_START  = 3'd1;
  localparam logic [STATE_W-1:0] S_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [STATE_W-1:0] S_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [STATE_W-1:0] S_AFTER_DATA = S_STOP;
`endif

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               sync1;
  logic               sync2;
  logic               rx_prev;
  logic               rx_s;
  logic               tick;
`ifdef UART_RX_PARITY_EN
  logic               parity_bit;
`endif

  assign rx_s = sync2;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (rx_prev && !rx_s) begin
          next_state = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          next_state = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && (bit_idx == 3'd7)) begin
          next_state = S_AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          next_state = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // START waits half a bit so every later sample lands mid-bit
  always_comb begin
    busy = (state != S_IDLE);
    tick = (state == S_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);
  end

  // Synchronizer, timing counter, shift register and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rx_prev    <= 1'b1;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      sync1      <= rx_in;
      sync2      <= sync1;
      rx_prev    <= sync2;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      if ((state == S_IDLE) || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (state == S_IDLE) begin
        bit_idx <= 3'd0;
      end else if ((state == S_DATA) && tick) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

`ifdef UART_RX_PARITY_EN
      if ((state == S_PARITY) && tick) begin
        parity_bit <= rx_s;
      end
`endif

      if ((state == S_STOP) && tick) begin
        rx_data   <= shift;
        rx_valid  <= 1'b1;
        frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
        parity_err <= ^{shift, parity_bit};
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// Scoreboard bench for uart_rx: random frames vs. a frame-level expectation queue.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_in    (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every delivered byte against the oldest expected frame
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        chk("valid_not_consecutive", int'(prev_valid), 0);
        if (q.size() == 0) begin
          chk("unexpected_rx_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rx_data", int'(rx_data), int'(e.d));
          chk("frame_err", int'(frame_err), int'(e.fe));
          chk("parity_err", int'(parity_err), int'(e.pe));
        end
      end else begin
        chk("err_flags_idle", int'({frame_err, parity_err}), 0);
      end
    end
    prev_valid = rx_valid;
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Expected result is derived from the frame content, pushed before driving
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par, input int gap);
    exp_t e;
    e.d  = d;
    e.fe = ~stop;
`ifdef UART_RX_PARITY_EN
    e.pe = (^d) ^ par;
`else
    e.pe = 1'b0;
`endif
    q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
    rx_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 400 && q.size() != 0; k++) @(negedge clk);
    chk(name, q.size(), 0);
  endtask

  initial begin
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_parity_err", int'(parity_err), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0x55 with a good stop bit
    send_frame(8'h55, 1'b1, 1'b0, 10);
    drain("drain_55");
    repeat (2) @(negedge clk);
    chk("busy_after_55", int'(busy), 0);

    // False start: short low pulse
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_on_false_start", int'(busy), 1);
    rx_in = 1'b1;
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    chk("false_start_idle", int'(busy), 0);
    repeat (10) @(negedge clk);

    // Stop bit driven low
    send_frame(8'hA3, 1'b0, 1'b1, 8);
    drain("drain_a3");

    // Reset in the middle of data bit 3 of an 0xA5 frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx_in = 1'b0;
    repeat (8) @(negedge clk);
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_in_reset", int'(busy), 0);
    chk("valid_in_reset", int'(rx_valid), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b0, 6);
    drain("drain_3c");

    // Back-to-back with no idle gap
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 6);
    drain("drain_b2b");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 6);
    send_frame(8'h07, 1'b1, 1'b0, 6);
    drain("drain_parity");
`endif

    // Random frames; a low stop bit needs an idle gap before the next edge
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      logic       stop;
      logic       par;
      int         gap;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      par  = 1'($urandom_range(0, 1));
      gap  = stop ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20));
      send_frame(d, stop, par, gap);
    end
    drain("drain_random");
    repeat (5) @(negedge clk);
    chk("busy_end", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
